// File: rtl/prim_diff_pkg.sv
// Shared types for the differential event link: handshake states and pair encodings.
package prim_diff_pkg;

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Phase1 = 2'd1,
    Phase2 = 2'd2,
    Pause  = 2'd3
  } state_e;

  typedef struct packed {
    logic p;
    logic n;
  } diff_pair_t;

  localparam diff_pair_t PairIdle   = '{p: 1'b0, n: 1'b1};
  localparam diff_pair_t PairActive = '{p: 1'b1, n: 1'b0};
  // Both wires high is an illegal code; the far end must flag it.
  localparam diff_pair_t PairForce  = '{p: 1'b1, n: 1'b1};

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-stage synchronizer for signals entering this clock domain.
module prim_flop_2sync #(
  parameter int unsigned      Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= ResetValue;
      q_o      <= ResetValue;
    end else begin
      stage1_q <= d_i;
      q_o      <= stage1_q;
    end
  end

endmodule

// File: rtl/prim_diff_pulse_sender.sv
// Sender side of a differential event link: one full four-phase handshake per
// requested event, with ack integrity checking, timeout and forced-error injection.
module prim_diff_pulse_sender
  import prim_diff_pkg::*;
#(
  parameter bit          AsyncOn       = 1'b0,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic err_force_i,
  input  logic ack_pi,
  input  logic ack_ni,
  output logic diff_po,
  output logic diff_no,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o,
  output logic sigint_o
);

  localparam int unsigned CntW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned CntMaxInt = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [CntW-1:0] CntMax = CntW'(CntMaxInt);

  logic ack_p, ack_n, ack_ok, ack_lvl;

  if (AsyncOn) begin : gen_async
    logic sync_rst_n;
    logic ack_p_q, ack_n_q, invalid_q, toggled;

    assign sync_rst_n = ~rst_i;

    prim_flop_2sync #(.Width(1), .ResetValue(1'b0)) u_sync_p (
      .clk_i  (clk_i),
      .rst_ni (sync_rst_n),
      .d_i    (ack_pi),
      .q_o    (ack_p)
    );

    prim_flop_2sync #(.Width(1), .ResetValue(1'b1)) u_sync_n (
      .clk_i  (clk_i),
      .rst_ni (sync_rst_n),
      .d_i    (ack_ni),
      .q_o    (ack_n)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        ack_p_q   <= 1'b0;
        ack_n_q   <= 1'b1;
        invalid_q <= 1'b0;
      end else begin
        ack_p_q   <= ack_p;
        ack_n_q   <= ack_n;
        invalid_q <= ~ack_ok;
      end
    end

    // The two wires may resolve one cycle apart; only a lone invalid cycle
    // accompanied by a transition is forgiven.
    assign toggled  = (ack_p != ack_p_q) || (ack_n != ack_n_q);
    assign sigint_o = ~ack_ok && (invalid_q || ~toggled);
  end else begin : gen_sync
    assign ack_p    = ack_pi;
    assign ack_n    = ack_ni;
    assign sigint_o = ~ack_ok;
  end

  assign ack_ok  = ack_p ^ ack_n;
  assign ack_lvl = ack_p;

  state_e          state_q, state_d;
  logic            pending_q, pending_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  diff_pair_t      pair_d;
  logic            done_d, timeout_d, launch, timeout_hit, in_phase_d;

  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntMax);
  assign in_phase_d  = (state_d == Phase1) || (state_d == Phase2);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    launch    = 1'b0;

    unique case (state_q)
      Idle: begin
        if (req_i || pending_q) begin
          state_d = Phase1;
          launch  = 1'b1;
        end
      end
      Phase1: begin
        if (ack_ok && ack_lvl) begin
          state_d = Phase2;
        end else if (timeout_hit) begin
          state_d   = Pause;
          timeout_d = 1'b1;
        end
      end
      Phase2: begin
        if (ack_ok && !ack_lvl) begin
          state_d = Pause;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d   = Pause;
          timeout_d = 1'b1;
        end
      end
      Pause: begin
        if (pending_q) begin
          state_d = Phase1;
          launch  = 1'b1;
        end else begin
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase

    // A request arriving with a launch is absorbed by that launch.
    pending_d = pending_q;
    if (launch) begin
      pending_d = 1'b0;
    end else if (req_i && (state_q != Idle)) begin
      pending_d = 1'b1;
    end

    cnt_d = '0;
    if (TimeoutCycles != 0 && in_phase_d && (state_d == state_q) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (TimeoutCycles != 0 && in_phase_d && (state_d == state_q)) begin
      cnt_d = cnt_q;
    end

    pair_d = (state_d == Phase1) ? PairActive : PairIdle;
    if (err_force_i) begin
      pair_d = PairForce;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      diff_po   <= PairIdle.p;
      diff_no   <= PairIdle.n;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      diff_po   <= pair_d.p;
      diff_no   <= pair_d.n;
      busy_o    <= (state_d != Idle);
      done_o    <= done_d;
      timeout_o <= timeout_d;
    end
  end

endmodule
